// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a byte stream with a valid/ready handshake. The stream holds a 16-bit
// word count N, then 4*N data bytes with each word sent least-significant byte
// first, then one XOR checksum byte. Each assembled word is written at the next
// word address starting from 0. The busy output holds off the CPU until the
// checksum has been checked.
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    localparam logic [15:0]     DEPTH_W16 = 16'(DEPTH);
    localparam logic [ADDR_W:0] WL_ONE    = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_r;
    logic [7:0]        n_lo_r;
    logic [ADDR_W:0]   n_words_r;
    logic [1:0]        byte_cnt_r;
    logic [23:0]       lane_r;
    logic [7:0]        csum_r;

    logic              xfer_s;
    logic [15:0]       n_full_s;
    logic              hdr_bad_s;
    logic [ADDR_W:0]   wl_inc_s;
    logic [31:0]       addr_s;

    assign xfer_s    = rx_valid & rx_ready;
    assign n_full_s  = {rx_data, n_lo_r};
    assign hdr_bad_s = (n_full_s == 16'd0) || (n_full_s > DEPTH_W16);
    assign wl_inc_s  = words_loaded + WL_ONE;
    // The word index is always below DEPTH when a write is issued, so the top bit of words_loaded is not needed here.
    assign addr_s    = {{(30 - ADDR_W){1'b0}}, words_loaded[ADDR_W-1:0], 2'b00};

    // Load FSM: every output is a register that is updated on the same edge as the state it decodes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            n_lo_r       <= 8'd0;
            n_words_r    <= '0;
            byte_cnt_r   <= 2'd0;
            lane_r       <= 24'd0;
            csum_r       <= 8'd0;
            rx_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_r      <= S_HDR0;
                        rx_ready     <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        byte_cnt_r   <= 2'd0;
                        csum_r       <= 8'd0;
                    end
                end
                S_HDR0: begin
                    if (xfer_s) begin
                        n_lo_r  <= rx_data;
                        state_r <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (xfer_s) begin
                        if (hdr_bad_s) begin
                            state_r  <= S_ERR;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            n_words_r <= n_full_s[ADDR_W:0];
                            state_r   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
                        csum_r     <= csum_r ^ rx_data;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            // The fourth byte goes directly into lane 3 of the write data.
                            mem_wdata <= {rx_data, lane_r};
                            mem_addr  <= addr_s;
                            mem_we    <= 1'b1;
                            rx_ready  <= 1'b0;
                            state_r   <= S_WRITE;
                        end else begin
                            case (byte_cnt_r)
                                2'd0:    lane_r[7:0]   <= rx_data;
                                2'd1:    lane_r[15:8]  <= rx_data;
                                2'd2:    lane_r[23:16] <= rx_data;
                                default: lane_r        <= lane_r;
                            endcase
                        end
                    end
                end
                S_WRITE: begin
                    mem_we       <= 1'b0;
                    rx_ready     <= 1'b1;
                    words_loaded <= wl_inc_s;
                    state_r      <= (wl_inc_s == n_words_r) ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    if (xfer_s) begin
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (rx_data == csum_r) begin
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            error   <= 1'b1;
                            state_r <= S_ERR;
                        end
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    rx_ready <= 1'b0;
                    mem_we   <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
